seven_seg_scan: RTL

- Multiplexed seven-segment scan driver, directly downstream of the clock divider.
- Samples the divider's scan-rate tap (the toggle-rate output) as a level on scan_tick and advances one digit per rising edge, all within the clk domain. scan_tick is never used as a clock.
- Inserts an anti-ghosting blank interval between digits.
- Double-buffers the display value so a frame never shows mixed old and new digits.
- Drives the board's anode and segment pins.

---
 rtl/seven_seg_scan.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scan driver: advances one digit per rising edge of the
// divider's scan_tick level, blanks between digits, and double-buffers the display value.
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic                            scan_tick,
    input  logic [4*NUM_DIGITS-1:0]         value,
    input  logic [NUM_DIGITS-1:0]           dp_in,
    input  logic                            blank_lz,
    input  logic                            load,
    output logic [NUM_DIGITS-1:0]           an,
    output logic [6:0]                      seg,
    output logic                            dp,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic                  POL      = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{POL}};
    localparam logic [6:0]            SEG_OFF  = {7{POL}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic                    tick_d;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] active_val;
    logic [NUM_DIGITS-1:0]   active_dp;

    logic                    tick_edge;
    logic                    wrap;
    logic [3:0]              nibble;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    all_zero;
    logic                    suppress;
    logic [NUM_DIGITS-1:0]   digit_sel;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    assign tick_edge = scan_tick & ~tick_d;
    assign wrap      = (state == ST_SHOW) && tick_edge && (digit_idx == IDX_LAST);
    assign nibble    = active_val[4*int'(digit_idx) +: 4];
    assign digit_sel = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;

    // lead_zero[i] is set when every nibble from the top digit down to i is zero
    always_comb begin
        lead_zero = '0;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero & (active_val[4*i +: 4] == 4'h0);
            lead_zero[i] = all_zero;
        end
        suppress = blank_lz && (digit_idx != '0) && lead_zero[digit_idx];
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            tick_d     <= 1'b0;
            digit_idx  <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= POL;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
        end else begin
            tick_d     <= scan_tick;
            frame_done <= 1'b0;

            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end

            if (state == ST_BLANK) begin
                if (cnt == CNT_LAST) begin
                    state <= ST_SHOW;
                    if (suppress) begin
                        an  <= AN_OFF;
                        seg <= SEG_OFF;
                        dp  <= POL;
                    end else begin
                        an  <= digit_sel ^ AN_OFF;
                        seg <= hex_to_seg(nibble) ^ SEG_OFF;
                        dp  <= active_dp[digit_idx] ^ POL;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (tick_edge) begin
                state     <= ST_BLANK;
                cnt       <= '0;
                an        <= AN_OFF;
                seg       <= SEG_OFF;
                dp        <= POL;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end

            // A load landing on the wrap goes straight to active; this overrides the pending set above
            if (wrap) begin
                frame_done <= 1'b1;
                pending    <= 1'b0;
                if (load) begin
                    active_val <= value;
                    active_dp  <= dp_in;
                end else if (pending) begin
                    active_val <= shadow_val;
                    active_dp  <= shadow_dp;
                end
            end
        end
    end

endmodule
